// File: rtl/led_pkg.sv
// Shared encodings and initial-pattern constants for the LED sequencer.
// Imported by the command interface users and the sequencer itself.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_LOAD   = 3'd1,
    S_BLINK  = 3'd2,
    S_CHASE  = 3'd3,
    S_BOUNCE = 3'd4
  } state_t;

  localparam logic [7:0] LED_ALL_OFF = 8'h00;
  localparam logic [7:0] LED_ALL_ON  = 8'hFF;
  localparam logic [7:0] LED_FIRST   = 8'h01;
  localparam logic [7:0] LED_LAST    = 8'h80;

  function automatic logic [7:0] init_pattern(input mode_t m);
    case (m)
      MODE_BLINK:  return LED_ALL_ON;
      MODE_CHASE:  return LED_FIRST;
      MODE_BOUNCE: return LED_FIRST;
      default:     return LED_ALL_OFF;
    endcase
  endfunction

  function automatic state_t run_state(input mode_t m);
    case (m)
      MODE_BLINK:  return S_BLINK;
      MODE_CHASE:  return S_CHASE;
      MODE_BOUNCE: return S_BOUNCE;
      default:     return S_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Command channel into the LED sequencer: mode/period under valid/ready.
interface led_seq_ctrl_if #(
  parameter int PERIOD_W = 10
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/led_seq_ctrl_tick_gen.sv
// Base-tick prescaler: one-cycle strobe every TICK_DIV clocks, restartable by clear.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == LAST) && !clear;

endmodule

// File: rtl/led_seq_ctrl.sv
// Commandable pattern engine for the 8-LED bank: OFF, BLINK, CHASE, BOUNCE,
// stepped every period base ticks.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int PERIOD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_seq_ctrl_if.slave        cmd,
  output logic [8:1]           led,
  output logic                 step_pulse
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  state_t              state;
  mode_t               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] step_cnt;
  logic                dir_down;
  logic                ready_q;

  logic                accept;
  logic                tick_clear;
  logic                tick;
  logic                running;
  logic                step_evt;
  logic [7:0]          chase_nxt;
  logic [7:0]          bounce_nxt;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid & ready_q;

  // Timebase restarts on accept and again on the load cycle, so the first
  // step lands a full period after the initial pattern appears.
  assign tick_clear = accept | (state == S_LOAD);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign running  = (state == S_BLINK) || (state == S_CHASE) || (state == S_BOUNCE);
  assign step_evt = running && tick && (step_cnt == period_q - ONE);

  assign chase_nxt  = {led[7:1], led[8]};
  assign bounce_nxt = dir_down ? {1'b0, led[8:2]} : {led[7:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (tick_clear || step_evt) begin
      step_cnt <= '0;
    end else if (running && tick) begin
      step_cnt <= step_cnt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      mode_q     <= MODE_OFF;
      period_q   <= '0;
      dir_down   <= 1'b0;
      ready_q    <= 1'b1;
      led        <= LED_ALL_OFF;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (accept) begin
        // A new command aborts whatever pattern is running, same mode included.
        mode_q   <= mode_t'(cmd.cmd_mode);
        period_q <= (cmd.cmd_period == '0) ? ONE : cmd.cmd_period;
        state    <= S_LOAD;
        ready_q  <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            led      <= init_pattern(mode_q);
            dir_down <= 1'b0;
            state    <= run_state(mode_q);
            ready_q  <= 1'b1;
          end
          S_OFF: begin
            led <= LED_ALL_OFF;
          end
          S_BLINK: begin
            if (step_evt) begin
              led        <= ~led;
              step_pulse <= 1'b1;
            end
          end
          S_CHASE: begin
            if (step_evt) begin
              led        <= chase_nxt;
              step_pulse <= 1'b1;
            end
          end
          S_BOUNCE: begin
            if (step_evt) begin
              led        <= bounce_nxt;
              step_pulse <= 1'b1;
              // Flip on reaching an end so each end LED is lit for one step only.
              if (bounce_nxt == LED_LAST) begin
                dir_down <= 1'b1;
              end else if (bounce_nxt == LED_FIRST) begin
                dir_down <= 1'b0;
              end
            end
          end
          default: begin
            state   <= S_OFF;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus random commands
// against a pattern-by-step-index reference model.
module tb_led_seq_ctrl;
  import led_pkg::*;

  localparam int TD = 4;
  localparam int PW = 10;

  logic       clk;
  logic       rst_n;
  logic [8:1] led;
  logic       step_pulse;

  led_seq_ctrl_if #(.PERIOD_W(PW)) bus ();

  led_seq_ctrl #(
    .TICK_DIV (TD),
    .PERIOD_W (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bus),
    .led        (led),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = idle after reset, 1 = load cycle, 2 = running j cycles
  // after the load edge.
  int         m_phase;
  int         m_mode;
  int         m_per;
  int         m_j;
  logic [7:0] m_hold;

  function automatic logic [7:0] pattern(input int mode, input int s);
    int p;
    int idx;
    case (mode)
      1: return (s % 2 == 0) ? 8'hFF : 8'h00;
      2: return 8'(1 << (s % 8));
      3: begin
        p   = s % 14;
        idx = (p <= 7) ? p : 14 - p;
        return 8'(1 << idx);
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_led();
    if (m_phase == 1) return m_hold;
    if (m_phase == 2) return pattern(m_mode, m_j / (TD * m_per));
    return 8'h00;
  endfunction

  function automatic logic exp_ready();
    return (m_phase != 1);
  endfunction

  function automatic logic exp_pulse();
    return (m_phase == 2) && (m_mode != 0) && (m_j > 0) && (m_j % (TD * m_per) == 0);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("led", led, exp_led());
    check("cmd_ready", {7'b0, bus.cmd_ready}, {7'b0, exp_ready()});
    check("step_pulse", {7'b0, step_pulse}, {7'b0, exp_pulse()});
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_mode  = 0;
    m_per   = 1;
    m_j     = 0;
    m_hold  = 8'h00;
  endtask

  task automatic model_advance(input logic acc, input logic [1:0] md, input logic [PW-1:0] pd);
    if (acc) begin
      m_hold  = exp_led();
      m_phase = 1;
      m_mode  = int'(md);
      m_per   = (pd == '0) ? 1 : int'(pd);
      m_j     = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_j     = 0;
    end else if (m_phase == 2) begin
      m_j++;
    end
  endtask

  // Called at a falling edge: check, drive the next inputs, advance the model.
  task automatic run_cycle(input logic v, input logic [1:0] md, input logic [PW-1:0] pd);
    check_outputs();
    bus.cmd_valid  = v;
    bus.cmd_mode   = md;
    bus.cmd_period = pd;
    model_advance(v && exp_ready(), md, pd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 2'd0, '0);
  endtask

  initial begin
    logic [1:0]    rmd;
    logic [PW-1:0] rpd;
    logic          rv;
    int            n;

    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_mode   = 2'd2;
    bus.cmd_period = PW'(1);
    model_reset();

    // Reset held three cycles with a command pending: nothing is accepted.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    idle(4);

    // BLINK, period 3
    run_cycle(1'b1, 2'd1, PW'(3));
    idle(50);

    // CHASE, period 1, through a wrap
    run_cycle(1'b1, 2'd2, PW'(1));
    idle(40);

    // BOUNCE, period 1, a full out-and-back
    run_cycle(1'b1, 2'd3, PW'(1));
    idle(70);

    // Period 0 behaves as period 1
    run_cycle(1'b1, 2'd2, PW'(0));
    idle(14);

    // Abort mid-CHASE at 8'h08 with BLINK
    run_cycle(1'b1, 2'd2, PW'(1));
    n = 0;
    while (!(m_phase == 2 && exp_led() == 8'h08) && n < 100) begin
      run_cycle(1'b0, 2'd0, '0);
      n++;
    end
    run_cycle(1'b1, 2'd1, PW'(1));
    idle(12);

    // Command held through the load cycle is taken on the following cycle
    run_cycle(1'b1, 2'd3, PW'(2));
    run_cycle(1'b1, 2'd2, PW'(1));
    run_cycle(1'b1, 2'd2, PW'(1));
    idle(12);

    // OFF command
    run_cycle(1'b1, 2'd0, PW'(5));
    idle(20);

    // Async reset between edges during BOUNCE
    run_cycle(1'b1, 2'd3, PW'(1));
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1'b0, 2'd0, '0);
    checks++;
    assert (dut.state === S_OFF)
    else begin
      failures++;
      $error("FAIL state_after_reset got=%0d exp=%0d", dut.state, S_OFF);
    end
    idle(6);

    // Random commands, including aborts and zero periods
    for (int i = 0; i < 1500; i++) begin
      rv  = ($urandom_range(0, 24) == 0);
      rmd = 2'($urandom_range(0, 3));
      rpd = PW'($urandom_range(0, 3));
      run_cycle(rv, rmd, rpd);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the 8-LED bank on the EPM570 board. Accepts a mode/period command over a valid/ready handshake and drives the bank through OFF, BLINK, CHASE or BOUNCE patterns. Timing comes from an internal millisecond prescaler off the 50 MHz board clock. It sits between a command source (button decoder, UART, test bench) and the `led[8:1]` pins, and replaces free-running toggle logic with a commandable pattern engine.

## Interface
- `TICK_DIV`, 50000: clocks per base tick (1 ms at 50 MHz); benches override it to a small value.
- `PERIOD_W`, 10: width of the step-period field, in ticks.
- `clk`  in  1  board clock, 50 MHz; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_mode`  in  2  0=OFF, 1=BLINK, 2=CHASE, 3=BOUNCE.
- `cmd_period`  in  PERIOD_W  ticks per pattern step; 0 is treated as 1.
- `led`  out  [8:1]  registered LED drive, 1 = lit.
- `step_pulse`  out  1  one-cycle strobe, high in the same cycle `led` takes a new step value.

## Operation
- States: S_OFF, S_LOAD, S_BLINK, S_CHASE, S_BOUNCE.
- Reset values: state S_OFF, `led`=8'h00, `cmd_ready`=1, `step_pulse`=0. The prescaler, step counter, period register and bounce direction are all 0.
- Accept: `cmd_valid & cmd_ready` on a rising edge.
  - Latch mode and period (0 forced to 1).
  - Go to S_LOAD.
  - Clear the prescaler and step counter.
- S_LOAD lasts exactly one cycle with `cmd_ready`=0.
  - Loads the initial pattern: OFF 8'h00, BLINK 8'hFF, CHASE 8'h01, BOUNCE 8'h01 with direction up.
  - Then goes to the state for the latched mode.
- `cmd_ready`=1 in every state except S_LOAD. A command arriving while `cmd_ready`=0 is not consumed, and the source holds it.
- A new command aborts the current pattern immediately in any state, including the same mode. The pattern restarts from its initial value.
- Step event: a tick occurs while the step counter equals period-1. On that event the counter clears; otherwise each tick increments it.
- S_OFF: `led` held at 0. No step events and no `step_pulse`.
- S_BLINK, on each step: `led <= ~led`.
- S_CHASE, on each step: rotate left, `led[1]`→`led[2]`…`led[8]`→`led[1]`. Wrap is 8'h80→8'h01.
- S_BOUNCE, on each step:
  - Up: shift left. When the result is 8'h80, direction flips to down.
  - Down: shift right. When the result is 8'h01, direction flips to up.
  - The end LEDs are lit for one step each, never two.
- Arithmetic:
  - Prescaler is `$clog2(TICK_DIV)` bits and wraps at TICK_DIV-1.
  - Step counter is PERIOD_W bits and is compared against period-1 with no overflow possible.
- `rst_n` low at any time forces reset values asynchronously. This includes mid-LOAD and mid-step. Operation resumes in S_OFF after deassertion.

## Timing
- Tick: one-cycle internal strobe, once every TICK_DIV clocks, counted from the S_LOAD cycle.
- Accept at edge N:
  - S_LOAD occupies cycle N+1.
  - The initial pattern is visible on `led` after edge N+1.
  - `cmd_ready` returns high after edge N+1.
- First step: TICK_DIV × period clocks after the S_LOAD edge; steps then repeat at the same interval.
- The `led` update and `step_pulse` are registered together, on the edge following the internal step event.
- `step_pulse` is never high in S_OFF or S_LOAD.
- Max step interval: 1023 ms with the defaults.

## Structure
- Shared package `led_pkg` holds:
  - mode encodings MODE_OFF/BLINK/CHASE/BOUNCE;
  - state encodings;
  - initial-pattern constants LED_ALL_OFF=8'h00, LED_ALL_ON=8'hFF, LED_FIRST=8'h01, LED_LAST=8'h80.
- One sub-module, `tick_gen`: parameterised by TICK_DIV, with inputs clk, rst_n and clear, and output tick. It is reusable by other board demos.
- FSM, step counter and pattern register stay in `led_seq_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold `rst_n`=0 for 3 cycles with `cmd_valid`=1 → `led`=8'h00, `cmd_ready`=1, `step_pulse`=0, and no accept.
- BLINK, period 3: accept → `led`=8'hFF after one cycle. Then 8'h00, 8'hFF, … every 12 clocks, with one `step_pulse` per change.
- CHASE, period 1: accept → 8'h01, 8'h02 … 8'h80, then 8'h01, every 4 clocks.
- BOUNCE, period 1: accept → sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02; each end value is held for exactly 4 clocks.
- Handshake/abort:
  - cmd_period=0 → treated as 1 (steps every 4 clocks).
  - Mid-CHASE at 8'h08, issue BLINK → `cmd_ready`=0 for exactly one cycle, then `led`=8'hFF, and the next step is 4 clocks later.
  - A `cmd_valid` held during S_LOAD is accepted only on the following cycle.
- Async reset mid-pattern: drop `rst_n` between clock edges during BOUNCE → `led`=8'h00 immediately without a clock edge, and the state is S_OFF after release.
